// File: rtl/iir_biquad_cascade_if.sv
// Sample stream, coefficient write port and state-clear strobe of the biquad cascade.
// The slave modport faces the filter and the master modport faces its driver.
interface iir_biquad_cascade_if #(
    parameter int DATA_W = 16,
    parameter int COEF_W = 18,
    parameter int N_SEC  = 4,
    parameter int N_CH   = 2
);
    localparam int CH_W   = (N_CH > 1) ? $clog2(N_CH) : 1;
    localparam int ADDR_W = $clog2(N_SEC * 5);

    logic                     i_valid;
    logic                     o_ready;
    logic [CH_W-1:0]          i_ch;
    logic signed [DATA_W-1:0] audio_in;
    logic                     o_valid;
    logic [CH_W-1:0]          o_ch;
    logic signed [DATA_W-1:0] audio_out;
    logic                     o_sat;
    logic                     i_coef_we;
    logic [ADDR_W-1:0]        i_coef_addr;
    logic signed [COEF_W-1:0] i_coef_data;
    logic                     i_clear;

    modport slave (
        input  i_valid, i_ch, audio_in, i_coef_we, i_coef_addr, i_coef_data, i_clear,
        output o_ready, o_valid, o_ch, audio_out, o_sat
    );

    modport master (
        output i_valid, i_ch, audio_in, i_coef_we, i_coef_addr, i_coef_data, i_clear,
        input  o_ready, o_valid, o_ch, audio_out, o_sat
    );
endinterface

// File: rtl/iir_biquad_cascade.sv
// Multi-channel cascade of Direct-Form-I biquads sharing one multiplier.
// Each section takes five MAC cycles; the saturated result of a section feeds the next one.
module iir_biquad_cascade #(
    parameter int DATA_W = 16,
    parameter int COEF_W = 18,
    parameter int FRAC_W = 14,
    parameter int N_SEC  = 4,
    parameter int N_CH   = 2
) (
    input  logic                  clk,
    input  logic                  i_rst_n,
    iir_biquad_cascade_if.slave   bus
);
    localparam int CH_W   = (N_CH > 1) ? $clog2(N_CH) : 1;
    localparam int SEC_W  = (N_SEC > 1) ? $clog2(N_SEC) : 1;
    localparam int N_COEF = N_SEC * 5;
    localparam int ADDR_W = $clog2(N_COEF);
    localparam int ACC_W  = DATA_W + COEF_W + 3;
    localparam int PROD_W = DATA_W + COEF_W;

    localparam logic signed [COEF_W-1:0] COEF_ONE = COEF_W'(2 ** FRAC_W);
    localparam logic signed [ACC_W-1:0]  Y_MAX    = ACC_W'(2 ** (DATA_W - 1) - 1);
    localparam logic signed [ACC_W-1:0]  Y_MIN    = ~Y_MAX;

    typedef enum logic [1:0] {IDLE, MAC, OUT} state_t;

    state_t state, state_nx;

    logic signed [COEF_W-1:0] coef_q [N_COEF];
    logic signed [DATA_W-1:0] x1_q [N_CH][N_SEC];
    logic signed [DATA_W-1:0] x2_q [N_CH][N_SEC];
    logic signed [DATA_W-1:0] y1_q [N_CH][N_SEC];
    logic signed [DATA_W-1:0] y2_q [N_CH][N_SEC];

    logic [SEC_W-1:0]         sec;
    logic [2:0]               k;
    logic signed [ACC_W-1:0]  acc;
    logic signed [DATA_W-1:0] cur_x;
    logic [CH_W-1:0]          ch_q;
    logic                     sat_any;

    logic                     accept;
    logic                     last_tap;
    logic                     last_sec;
    logic [ADDR_W-1:0]        coef_idx;
    logic signed [COEF_W-1:0] coef_sel;
    logic signed [DATA_W-1:0] operand;
    logic signed [PROD_W-1:0] prod;
    logic signed [ACC_W-1:0]  prod_ext;
    logic signed [ACC_W-1:0]  acc_nx;
    logic signed [ACC_W-1:0]  shifted;
    logic signed [DATA_W-1:0] y_sat;
    logic                     sat_now;

    assign accept   = bus.i_valid && (state == IDLE);
    assign last_tap = (k == 3'd4);
    assign last_sec = (sec == SEC_W'(N_SEC - 1));

    // Shared MAC datapath: tap k selects both the coefficient and the delay-line operand.
    always_comb begin
        // NOTE: every comb output gets a default first so no path can infer a latch.
        operand  = cur_x;
        coef_idx = ADDR_W'(sec) * ADDR_W'(5) + ADDR_W'(k);
        coef_sel = coef_q[coef_idx];
        unique case (k)
            3'd1:    operand = x1_q[ch_q][sec];
            3'd2:    operand = x2_q[ch_q][sec];
            3'd3:    operand = y1_q[ch_q][sec];
            3'd4:    operand = y2_q[ch_q][sec];
            default: operand = cur_x;
        endcase
        prod     = coef_sel * operand;
        prod_ext = ACC_W'(prod);
        acc_nx   = (k >= 3'd3) ? (acc - prod_ext) : (acc + prod_ext);
        shifted  = acc_nx >>> FRAC_W;
        sat_now  = 1'b0;
        y_sat    = shifted[DATA_W-1:0];
        if (shifted > Y_MAX) begin
            y_sat   = Y_MAX[DATA_W-1:0];
            sat_now = 1'b1;
        end else if (shifted < Y_MIN) begin
            y_sat   = Y_MIN[DATA_W-1:0];
            sat_now = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state <= IDLE;
        end else begin
            // NOTE: sequential state is always assigned with <= so all flops update together.
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:    if (accept) state_nx = MAC;
            MAC:     if (last_tap && last_sec) state_nx = OUT;
            OUT:     state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        bus.o_ready = (state == IDLE);
    end

    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            // NOTE: coefficients and delay lines are flop arrays, so they can be reset to a
            // known passthrough/zero state; a RAM macro would need an explicit init sequence.
            for (int a = 0; a < N_COEF; a++) begin
                coef_q[a] <= ((a % 5) == 0) ? COEF_ONE : '0;
            end
            for (int c = 0; c < N_CH; c++) begin
                for (int s = 0; s < N_SEC; s++) begin
                    x1_q[c][s] <= '0;
                    x2_q[c][s] <= '0;
                    y1_q[c][s] <= '0;
                    y2_q[c][s] <= '0;
                end
            end
            sec           <= '0;
            k             <= '0;
            acc           <= '0;
            cur_x         <= '0;
            ch_q          <= '0;
            sat_any       <= 1'b0;
            bus.o_valid   <= 1'b0;
            bus.o_ch      <= '0;
            bus.audio_out <= '0;
            bus.o_sat     <= 1'b0;
        end else begin
            bus.o_valid <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (bus.i_coef_we && (32'(bus.i_coef_addr) < N_COEF)) begin
                        coef_q[bus.i_coef_addr] <= bus.i_coef_data;
                    end
                    if (bus.i_clear) begin
                        for (int c = 0; c < N_CH; c++) begin
                            for (int s = 0; s < N_SEC; s++) begin
                                x1_q[c][s] <= '0;
                                x2_q[c][s] <= '0;
                                y1_q[c][s] <= '0;
                                y2_q[c][s] <= '0;
                            end
                        end
                    end
                    if (accept) begin
                        sec     <= '0;
                        k       <= '0;
                        acc     <= '0;
                        cur_x   <= bus.audio_in;
                        ch_q    <= (32'(bus.i_ch) < N_CH) ? bus.i_ch : '0;
                        sat_any <= 1'b0;
                    end
                end
                MAC: begin
                    if (last_tap) begin
                        x2_q[ch_q][sec] <= x1_q[ch_q][sec];
                        x1_q[ch_q][sec] <= cur_x;
                        y2_q[ch_q][sec] <= y1_q[ch_q][sec];
                        y1_q[ch_q][sec] <= y_sat;
                        cur_x           <= y_sat;
                        sat_any         <= sat_any | sat_now;
                        acc             <= '0;
                        k               <= '0;
                        if (!last_sec) sec <= sec + 1'b1;
                    end else begin
                        acc <= acc_nx;
                        k   <= k + 3'd1;
                    end
                end
                OUT: begin
                    // cur_x now holds the last section's output.
                    bus.o_valid   <= 1'b1;
                    bus.audio_out <= cur_x;
                    bus.o_ch      <= ch_q;
                    bus.o_sat     <= sat_any;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: doc/iir_biquad_cascade.md
Name: iir_biquad_cascade

Overview:
- Multi-channel, multi-section IIR filter built from cascaded Direct-Form-I biquads. It sits in the audio path between the codec receive side and the DSP effects chain.
- Generalises the single external-state biquad. Per-channel delay-line state is held internally, coefficients are runtime-writable per section, and one time-multiplexed multiplier serves all sections and channels.
- Saturating output with a saturation indicator.

Parameters:
- DATA_W, 16: sample width, signed.
- COEF_W, 18: coefficient width, signed.
- FRAC_W, 14: coefficient fractional bits; 1.0 = 2^FRAC_W.
- N_SEC, 4: number of cascaded biquad sections, 1..8.
- N_CH, 2: number of independent channels, 1..4.

Ports:
- clk  in  1  system clock, rising edge.
- i_rst_n  in  1  asynchronous active-low reset.
- i_valid  in  1  input sample valid.
- o_ready  out  1  block idle, can accept a sample.
- i_ch  in  max(1,clog2(N_CH))  channel of input sample.
- audio_in  in  DATA_W  signed input sample.
- o_valid  out  1  output sample valid, 1-cycle pulse.
- o_ch  out  max(1,clog2(N_CH))  channel of output sample.
- audio_out  out  DATA_W  signed filtered sample.
- o_sat  out  1  any section saturated for this sample; qualified by o_valid.
- i_coef_we  in  1  coefficient write strobe.
- i_coef_addr  in  clog2(N_SEC*5)  coefficient address = sec*5 + k.
- i_coef_data  in  COEF_W  signed coefficient value.
- i_clear  in  1  synchronous clear of all channel delay state.

Behaviour:
- Clock and reset: one clock, clk. Reset i_rst_n is asynchronous and active-low.
- Reset values:
  - o_ready=1, o_valid=0, o_sat=0, audio_out=0, o_ch=0, FSM=IDLE.
  - All delay state is 0.
  - Every section is passthrough: b1=2^FRAC_W; b2, b3, a2, a3 = 0.
- Coefficient index k: 0=b1 (x[n]), 1=b2 (x[n-1]), 2=b3 (x[n-2]), 3=a2 (y[n-1]), 4=a3 (y[n-2]).
- Section equation: y = sat( (b1*x + b2*x1 + b3*x2 - a2*y1 - a3*y2) >>> FRAC_W ).
  - Accumulator width is DATA_W+COEF_W+3 bits; no internal overflow is possible.
  - Right shift is arithmetic (truncates toward -inf).
  - sat clamps to [-2^(DATA_W-1), 2^(DATA_W-1)-1].
- State storage: x1, x2, y1, y2 are held per (channel, section). Each section's saturated y is the next section's x. The last section's y is audio_out.
- Handshake:
  - A sample is accepted on a rising edge where i_valid && o_ready; audio_in and i_ch are captured.
  - i_valid while o_ready=0 is ignored (not queued).
- FSM:
  - IDLE: o_ready=1. On accept, go to MAC with sec=0, k=0, acc=0.
  - MAC: one product accumulated per cycle, k=0..4. At k=4 the section result is computed and saturated, and that channel's state updates (x2<=x1, x1<=x, y2<=y1, y1<=y). If sec==N_SEC-1 go to OUT, else sec++ and k=0. Duration is 5*N_SEC cycles.
  - OUT: one cycle with o_valid=1; audio_out, o_ch and o_sat are valid. Then IDLE.
- Latency: o_valid is high in the cycle following edge E0+5*N_SEC+1, where E0 is the accept edge. Throughput is one sample per 5*N_SEC+2 cycles.
- Output holding: audio_out and o_ch hold their last values after o_valid drops.
- o_sat is the OR of saturation events across all sections for this sample.
- Coefficient writes:
  - Take effect on the write edge only when o_ready=1.
  - Writes while busy are dropped.
  - Addresses >= N_SEC*5 are ignored.
- i_clear: zeros all state for all channels when o_ready=1; ignored while busy. If i_clear and i_valid occur in the same cycle, the clear applies first and the sample is processed with zero history.
- Simultaneous coefficient write and accept: the write applies, and the new coefficient is used for that sample.
- Reset mid-operation: aborts immediately and returns to reset values. No o_valid is produced for the in-flight sample.
- i_ch >= N_CH: the sample is accepted but treated as channel 0.

Test Plan:
- Reset defaults, N_SEC=4: assert reset, release, accept audio_in=1234 on ch0 -> o_ready=1 before accept; o_valid exactly 21 edges after the accept edge; audio_out=1234, o_sat=0.
- Gain: write sec0 b1=8192 (0.5); input 1000 -> 500; input -1001 -> -501 (floor).
- Feedback impulse: sec0 b1=16384, a2=-8192; inputs 1000, 0, 0, 0 on ch0 -> outputs 1000, 500, 250, 125.
- Channel independence: with the same coefficients, interleave ch0=1000, ch1=0, ch0=0, ch1=0 -> ch0 gives 1000 then 500; ch1 gives 0, 0.
- Saturation: sec0 b1=32767; inputs 30000 and -30000 -> 32767 and -32768, each with o_sat=1 on the o_valid cycle.
- Busy and abort: a coefficient write during MAC is dropped (verify by readback via output); i_valid during MAC is not accepted; asserting i_rst_n low mid-MAC -> no o_valid, and all outputs return to reset values.
